run_perf_monitor: RTL

- Synthesizable run monitor for the RV32IMC + vector coprocessor top level.
- Watches the fetch-stage instruction and detects end of program from either a stuck instruction or a run of repeated NOPs.
- Counts total cycles, NOPs and per-unit gated-clock enables across NUM_CH channels.
- After end of program, scans data memory against an expected-image port and reports pass/fail counts and the first failing address.

---
 rtl/run_perf_monitor.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/run_perf_monitor.sv
// -----------------------------------------------------------------------------
// run_perf_monitor
//
// Run monitor for the RV32IMC + vector coprocessor top level.
//
// While the program runs, it counts total cycles, fetched NOPs and per-unit
// gated-clock enables. It decides that the program has ended when the fetch
// stage keeps presenting one identical instruction (stuck PC) or one identical
// NOP (idle loop) for long enough. It then walks data memory against an
// expected-image port and reports pass/fail counts and the first failing
// address.
//
// State sequence: RUN -> SCAN -> DRAIN -> REPORT -> (restart) -> RUN
//
// Ports
//   clk             system clock
//   nrst            synchronous active-low reset, priority over everything
//   inst            fetch-stage instruction
//   inst_valid      inst is meaningful this cycle
//   unit_clk_en     per-unit clock-gate enables, one bit per channel
//   restart         one-cycle pulse, honoured only in REPORT
//   mem_addr        scan read address to data memory and expected image
//   mem_rdata       data memory read data, RD_LAT cycles after mem_addr
//   exp_rdata       expected word, RD_LAT cycles after mem_addr
//   run_done        program has ended (SCAN, DRAIN, REPORT)
//   report_valid    results are final (REPORT)
//   cycle_cnt       cycles spent in RUN
//   nop_cnt         valid NOPs fetched in RUN
//   unit_cnt        per-channel enable counts, channel k at [k*CNT_W +: CNT_W]
//   pass_cnt        words that matched the expected image
//   fail_cnt        words that did not match
//   first_fail_addr address of the first mismatch
//   first_fail_vld  at least one mismatch has been seen
// -----------------------------------------------------------------------------
module run_perf_monitor #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned MAX_ADDR    = 335,
  parameter int unsigned STALL_LIMIT = 49,
  parameter int unsigned NOP_LIMIT   = 16,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [31:0]             inst,
  input  logic                    inst_valid,
  input  logic [NUM_CH-1:0]       unit_clk_en,
  input  logic                    restart,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [31:0]             mem_rdata,
  input  logic [31:0]             exp_rdata,
  output logic                    run_done,
  output logic                    report_valid,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        nop_cnt,
  output logic [NUM_CH*CNT_W-1:0] unit_cnt,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic [ADDR_W-1:0]       first_fail_addr,
  output logic                    first_fail_vld
);

  // Trackers only need to reach their limit; they stop there.
  localparam int unsigned SAME_W = $clog2(STALL_LIMIT + 1);
  localparam int unsigned NOP_W  = $clog2(NOP_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SCAN,
    ST_DRAIN,
    ST_REPORT
  } state_e;

  // Saturating increment: statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]               nop_cnt_q, nop_cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   unit_cnt_q, unit_cnt_d;
  logic [31:0]                    last_inst_q, last_inst_d;
  logic [SAME_W-1:0]              same_cnt_q, same_cnt_d;
  logic [NOP_W-1:0]               nop_run_q, nop_run_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [RD_LAT-1:0]              pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0]  pipe_addr_q, pipe_addr_d;
  logic [CNT_W-1:0]               pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]               fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]              first_fail_addr_q, first_fail_addr_d;
  logic                           first_fail_vld_q, first_fail_vld_d;
  logic                           run_done_q, run_done_d;
  logic                           report_valid_q, report_valid_d;

  logic is_nop;
  logic run_exit;
  logic issue;
  logic tail_vld;
  logic soft_clr;

  // Compressed c.nop matches on the low halfword alone (upper half may hold
  // the next parcel); the 32-bit canonical NOP is addi x0,x0,0.
  assign is_nop   = (inst[15:0] == 16'h0001) || (inst == 32'h0000_0013);

  // Exit decision uses registered trackers, so the exit cycle is a full RUN
  // cycle and a simultaneous stall/NOP hit still produces one transition.
  assign run_exit = (same_cnt_q == SAME_W'(STALL_LIMIT)) ||
                    (nop_run_q  == NOP_W'(NOP_LIMIT));

  assign issue    = (state_q == ST_SCAN);
  assign tail_vld = pipe_vld_q[RD_LAT-1];

  // restart behaves exactly like reset, but only from REPORT.
  assign soft_clr = (state_q == ST_REPORT) && restart;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned; without these defaults synthesis infers latches.
    state_d           = state_q;
    cycle_cnt_d       = cycle_cnt_q;
    nop_cnt_d         = nop_cnt_q;
    unit_cnt_d        = unit_cnt_q;
    last_inst_d       = last_inst_q;
    same_cnt_d        = same_cnt_q;
    nop_run_d         = nop_run_q;
    addr_d            = addr_q;
    pass_cnt_d        = pass_cnt_q;
    fail_cnt_d        = fail_cnt_q;
    first_fail_addr_d = first_fail_addr_q;
    first_fail_vld_d  = first_fail_vld_q;

    // Read-latency matching pipeline: a token enters for every scan address
    // and leaves exactly when that address's read data is on the bus.
    pipe_vld_d[0]  = issue;
    pipe_addr_d[0] = addr_q;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end

    // Compare the word whose token is leaving the pipeline.
    if (tail_vld) begin
      if (mem_rdata == exp_rdata) begin
        pass_cnt_d = sat_inc(pass_cnt_q);
      end else begin
        fail_cnt_d = sat_inc(fail_cnt_q);
        if (!first_fail_vld_q) begin
          first_fail_addr_d = pipe_addr_q[RD_LAT-1];
          first_fail_vld_d  = 1'b1;
        end
      end
    end

    case (state_q)
      ST_RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (unit_clk_en[k]) unit_cnt_d[k] = sat_inc(unit_cnt_q[k]);
        end

        if (inst_valid) begin
          if (is_nop) nop_cnt_d = sat_inc(nop_cnt_q);

          if (inst == last_inst_q) begin
            // Trackers stop at their limit; the exit edge follows anyway.
            if (same_cnt_q != SAME_W'(STALL_LIMIT)) begin
              same_cnt_d = same_cnt_q + SAME_W'(1);
            end
            if (is_nop && (nop_run_q != NOP_W'(NOP_LIMIT))) begin
              nop_run_d = nop_run_q + NOP_W'(1);
            end
          end else begin
            last_inst_d = inst;
            same_cnt_d  = '0;
            nop_run_d   = '0;
          end
        end

        if (run_exit) state_d = ST_SCAN;
      end

      ST_SCAN: begin
        // The last address stays on the bus through DRAIN and REPORT.
        if (addr_q == ADDR_W'(MAX_ADDR)) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      ST_DRAIN: begin
        // Leave once the token being compared now is the last one in flight.
        if (pipe_vld_d == '0) state_d = ST_REPORT;
      end

      ST_REPORT: begin
        // Everything holds; restart is handled as a clear in the register.
      end

      default: state_d = ST_RUN;
    endcase

    run_done_d     = (state_d != ST_RUN);
    report_valid_d = (state_d == ST_REPORT);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!nrst || soft_clr) begin
      state_q           <= ST_RUN;
      cycle_cnt_q       <= '0;
      nop_cnt_q         <= '0;
      unit_cnt_q        <= '0;
      last_inst_q       <= '0;
      same_cnt_q        <= '0;
      nop_run_q         <= '0;
      addr_q            <= '0;
      pipe_vld_q        <= '0;
      pass_cnt_q        <= '0;
      fail_cnt_q        <= '0;
      first_fail_addr_q <= '0;
      first_fail_vld_q  <= 1'b0;
      run_done_q        <= 1'b0;
      report_valid_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      cycle_cnt_q       <= cycle_cnt_d;
      nop_cnt_q         <= nop_cnt_d;
      unit_cnt_q        <= unit_cnt_d;
      last_inst_q       <= last_inst_d;
      same_cnt_q        <= same_cnt_d;
      nop_run_q         <= nop_run_d;
      addr_q            <= addr_d;
      pipe_vld_q        <= pipe_vld_d;
      pass_cnt_q        <= pass_cnt_d;
      fail_cnt_q        <= fail_cnt_d;
      first_fail_addr_q <= first_fail_addr_d;
      first_fail_vld_q  <= first_fail_vld_d;
      run_done_q        <= run_done_d;
      report_valid_q    <= report_valid_d;
    end
  end

  // NOTE: token addresses carry no reset; they are only looked at while the
  // matching valid bit is set, and the valids are reset above.
  always_ff @(posedge clk) begin
    pipe_addr_q <= pipe_addr_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_addr        = addr_q;
  assign run_done        = run_done_q;
  assign report_valid    = report_valid_q;
  assign cycle_cnt       = cycle_cnt_q;
  assign nop_cnt         = nop_cnt_q;
  assign unit_cnt        = unit_cnt_q;
  assign pass_cnt        = pass_cnt_q;
  assign fail_cnt        = fail_cnt_q;
  assign first_fail_addr = first_fail_addr_q;
  assign first_fail_vld  = first_fail_vld_q;

endmodule
